text_pattern_loader: RTL and testbench
======================================

# text_pattern_loader

Writer side of the search datapath: accepts a byte stream over a valid/ready handshake and fills the pattern RAM and text RAM that the brute-force search engine reads. Once both memories are loaded, it pulses `start` to launch the search. It then holds off new input until the engine reports `search_done`. Malformed length headers are trapped in a sticky error state.

## Interface
- `PAT_AW`, 3: pattern RAM address width; max pattern length = 2^PAT_AW (8).
- `TXT_AW`, 8: text RAM address width; max text length = 2^TXT_AW − 1 (255).
- `DW`, 8: data byte width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in DW: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader can accept a byte; a transfer occurs on an edge where `in_valid && in_ready`.
- `pat_we` out 1: pattern RAM write enable.
- `pat_addr` out PAT_AW: pattern RAM write address.
- `pat_wdata` out DW: pattern RAM write data.
- `txt_we` out 1: text RAM write enable.
- `txt_addr` out TXT_AW: text RAM write address.
- `txt_wdata` out DW: text RAM write data.
- `pat_len` out PAT_AW+1: loaded pattern length.
- `txt_len` out TXT_AW: loaded text length.
- `start` out 1: one-cycle pulse that launches the search.
- `search_done` in 1: search engine finished.
- `busy` out 1: high in every state except IDLE and ERR.
- `err` out 1: sticky malformed-header flag.

## Operation
- Stream format: `P`, then P pattern bytes, then `T`, then T text bytes.
- States:
  - IDLE: `in_ready`=1. An accepted byte b with b==0 or b>2^PAT_AW → ERR. Otherwise `pat_len`←b, `idx`←0, → PAT_DATA.
  - PAT_DATA: each accepted byte is written to pattern address `idx`, then `idx`++. When the byte at `idx`==`pat_len`−1 is accepted, `idx`←0 and → TXT_LEN.
  - TXT_LEN: an accepted byte b with b==0 → ERR. Otherwise `txt_len`←b, → TXT_DATA.
  - TXT_DATA: each accepted byte is written to text address `idx`, then `idx`++. On the last byte (`idx`==`txt_len`−1) → START.
  - START: `start`=1 for exactly one cycle, then → WAIT.
  - WAIT: `in_ready`=0. `search_done`=1 → IDLE.
  - ERR: `err`=1, `in_ready`=0. Left only via `rst`.
- In START, WAIT and ERR, `in_ready`=0.
- `search_done` is ignored in every state except WAIT.
- `pat_len` and `txt_len` hold their values through WAIT and the following IDLE. They are overwritten only by the next accepted header.
- `idx` is TXT_AW bits wide. Comparisons are unsigned and zero-extended. Text length 255 writes addresses 0..254 with no wrap-around.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 from the first cycle after reset (IDLE). All other outputs are 0, including both lengths and all write enables. The state after reset is IDLE.
- `rst` asserted in any state, including mid-stream: the next cycle is IDLE with the reset values above. A partially written RAM is not cleared.
- Write latency: 1 cycle. For a byte accepted at edge k, `*_we`, `*_addr` and `*_wdata` are registered and valid during cycle k..k+1. `*_we` is low in all other cycles.
- Throughput: one byte per cycle. `in_valid` may stay high continuously.
- Start: last text byte accepted at edge N → `txt_we` high during cycle N..N+1, `start` high during cycle N+1..N+2. `start` is never asserted in the same cycle as a RAM write.
- `in_ready` falls at edge N (last text byte).
- Return to IDLE: `search_done` sampled high at edge M → `in_ready`=1 from edge M.
- `in_valid` while `in_ready`=0: no effect, byte not consumed.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t` {IDLE, PAT_DATA, TXT_LEN, TXT_DATA, START, WAIT, ERR};
  - default constants `PAT_AW`, `TXT_AW`, `DW`.
- Sub-module `byte_counter`: parameterised-width up-counter with synchronous clear and enable. Used for `idx`.
- The top level holds the FSM, the length registers and the output registers.

## Test plan
- Stream 04,'a','b','c','d',06,'x','a','b','c','d','y' with `in_valid` held high → pattern writes at addresses 0..3; text writes at addresses 0..5; `pat_len`=4, `txt_len`=6; `start` one cycle after the last `txt_we`; `in_ready`=0 until `search_done`.
- First byte 00, and separately first byte 09 → `err`=1 and `in_ready`=0, sticky for 20 cycles; `rst` → IDLE with `err`=0.
- Text length 255 with random `in_valid` gaps → exactly 255 `txt_we` pulses, last at address 254, no write while `in_valid`=0.
- `rst` pulsed after 2 of 4 pattern bytes → all outputs at reset values. A new full stream then loads correctly from address 0.
- `search_done` pulsed in IDLE and in TXT_DATA → ignored. `search_done` in WAIT → IDLE on the same edge, and `pat_len`/`txt_len` retained.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and default geometry for the search-datapath loader.
package loader_pkg;

  localparam int unsigned PAT_AW = 3;
  localparam int unsigned TXT_AW = 8;
  localparam int unsigned DW     = 8;

  typedef enum logic [2:0] {
    IDLE,
    PAT_DATA,
    TXT_LEN,
    TXT_DATA,
    START,
    WAIT,
    ERR
  } loader_state_t;

endpackage

// File: rtl/byte_counter.sv
// Up-counter with synchronous reset, synchronous clear and count enable.
module byte_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Clear has priority over increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/text_pattern_loader.sv
// Byte-stream loader: fills pattern and text RAMs, launches the search,
// then waits for the engine to finish. Bad length headers stick in ERR.
module text_pattern_loader
  import loader_pkg::*;
#(
  parameter int unsigned PAT_AW = loader_pkg::PAT_AW,
  parameter int unsigned TXT_AW = loader_pkg::TXT_AW,
  parameter int unsigned DW     = loader_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pat_we,
  output logic [PAT_AW-1:0] pat_addr,
  output logic [DW-1:0]     pat_wdata,
  output logic              txt_we,
  output logic [TXT_AW-1:0] txt_addr,
  output logic [DW-1:0]     txt_wdata,
  output logic [PAT_AW:0]   pat_len,
  output logic [TXT_AW-1:0] txt_len,
  output logic              start,
  input  logic              search_done,
  output logic              busy,
  output logic              err
);

  localparam logic [DW-1:0] PAT_MAX = DW'(2 ** PAT_AW);

  loader_state_t     state_q;
  logic              in_ready_q;
  logic              pat_we_q;
  logic [PAT_AW-1:0] pat_addr_q;
  logic [DW-1:0]     pat_wdata_q;
  logic              txt_we_q;
  logic [TXT_AW-1:0] txt_addr_q;
  logic [DW-1:0]     txt_wdata_q;
  logic [PAT_AW:0]   pat_len_q;
  logic [TXT_AW-1:0] txt_len_q;
  logic              start_q;
  logic              busy_q;
  logic              err_q;

  logic              accept;
  logic [TXT_AW-1:0] idx;
  logic [TXT_AW:0]   idx_inc;
  logic              pat_last;
  logic              txt_last;
  logic              pat_hdr_bad;
  logic              cnt_clr_d;
  logic              cnt_en_d;

  assign accept  = in_valid && in_ready_q;

  // One extra bit so that idx+1 never wraps, e.g. text length 255.
  assign idx_inc  = {1'b0, idx} + (TXT_AW + 1)'(1);
  assign pat_last = (idx_inc == (TXT_AW + 1)'(pat_len_q));
  assign txt_last = (idx_inc == {1'b0, txt_len_q});

  assign pat_hdr_bad = (in_data == '0) || (in_data > PAT_MAX);

  // Byte index control: restart at each section, advance per data byte.
  always_comb begin
    cnt_clr_d = 1'b0;
    cnt_en_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) cnt_clr_d = 1'b1;
      end
      PAT_DATA: begin
        if (accept) begin
          if (pat_last) cnt_clr_d = 1'b1;
          else          cnt_en_d  = 1'b1;
        end
      end
      TXT_DATA: begin
        if (accept) begin
          if (txt_last) cnt_clr_d = 1'b1;
          else          cnt_en_d  = 1'b1;
        end
      end
      default: begin
        cnt_clr_d = 1'b0;
        cnt_en_d  = 1'b0;
      end
    endcase
  end

  byte_counter #(
    .W(TXT_AW)
  ) u_idx (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr_d),
    .en_i   (cnt_en_d),
    .count_o(idx)
  );

  // Loader FSM with registered handshake, RAM-write and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      pat_we_q    <= 1'b0;
      pat_addr_q  <= '0;
      pat_wdata_q <= '0;
      txt_we_q    <= 1'b0;
      txt_addr_q  <= '0;
      txt_wdata_q <= '0;
      pat_len_q   <= '0;
      txt_len_q   <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pat_we_q <= 1'b0;
      txt_we_q <= 1'b0;
      start_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (pat_hdr_bad) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q   <= PAT_DATA;
              pat_len_q <= (PAT_AW + 1)'(in_data);
              busy_q    <= 1'b1;
            end
          end
        end
        PAT_DATA: begin
          if (accept) begin
            pat_we_q    <= 1'b1;
            pat_addr_q  <= idx[PAT_AW-1:0];
            pat_wdata_q <= in_data;
            if (pat_last) state_q <= TXT_LEN;
          end
        end
        TXT_LEN: begin
          if (accept) begin
            if (in_data == '0) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q   <= TXT_DATA;
              txt_len_q <= TXT_AW'(in_data);
            end
          end
        end
        TXT_DATA: begin
          if (accept) begin
            txt_we_q    <= 1'b1;
            txt_addr_q  <= idx;
            txt_wdata_q <= in_data;
            if (txt_last) begin
              state_q    <= START;
              in_ready_q <= 1'b0;
            end
          end
        end
        START: begin
          start_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (search_done) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Held low while reset is asserted, whatever state preceded it.
  assign in_ready  = in_ready_q && !rst;
  assign pat_we    = pat_we_q;
  assign pat_addr  = pat_addr_q;
  assign pat_wdata = pat_wdata_q;
  assign txt_we    = txt_we_q;
  assign txt_addr  = txt_addr_q;
  assign txt_wdata = txt_wdata_q;
  assign pat_len   = pat_len_q;
  assign txt_len   = txt_len_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_text_pattern_loader.sv
// Bench for text_pattern_loader: table of stream shapes with random payloads,
// random valid gaps and search_done noise, checked against a stream-level model.
`timescale 1ns/1ps
module tb_text_pattern_loader;

  localparam int PAT_AW = 3;
  localparam int TXT_AW = 8;
  localparam int DW     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              pat_we;
  logic [PAT_AW-1:0] pat_addr;
  logic [DW-1:0]     pat_wdata;
  logic              txt_we;
  logic [TXT_AW-1:0] txt_addr;
  logic [DW-1:0]     txt_wdata;
  logic [PAT_AW:0]   pat_len;
  logic [TXT_AW-1:0] txt_len;
  logic              start;
  logic              search_done = 1'b0;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  text_pattern_loader #(
    .PAT_AW(PAT_AW),
    .TXT_AW(TXT_AW),
    .DW    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pat_we     (pat_we),
    .pat_addr   (pat_addr),
    .pat_wdata  (pat_wdata),
    .txt_we     (txt_we),
    .txt_addr   (txt_addr),
    .txt_wdata  (txt_wdata),
    .pat_len    (pat_len),
    .txt_len    (txt_len),
    .start      (start),
    .search_done(search_done),
    .busy       (busy),
    .err        (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Write / start monitor, sampled on the falling edge.
  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t pat_log[$];
  wr_t txt_log[$];
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  start_cnt = 0;
  int  start_cyc = -1;
  int  last_txt_cyc = -1;
  int  overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pat_we) pat_log.push_back('{addr: int'(pat_addr), data: int'(pat_wdata)});
      if (txt_we) begin
        txt_log.push_back('{addr: int'(txt_addr), data: int'(txt_wdata)});
        last_txt_cyc <= cyc;
      end
      if (start) begin
        start_cnt <= start_cnt + 1;
        start_cyc <= cyc;
        if (pat_we || txt_we) overlap <= overlap + 1;
      end
    end
  end

  // Stream-level reference model: P, P bytes, T, T bytes.
  logic [7:0] stream[$];
  wr_t exp_pw[$];
  wr_t exp_tw[$];
  bit  exp_err = 1'b0;
  int  exp_pl = 0;
  int  exp_tl = 0;
  int  exp_consumed = 0;

  task automatic model;
    int p;
    int t;
    exp_pw.delete();
    exp_tw.delete();
    exp_err = 1'b0;
    p = int'(stream[0]);
    if (p == 0 || p > (1 << PAT_AW)) begin
      exp_err = 1'b1;
      exp_consumed = 1;
      return;
    end
    exp_pl = p;
    for (int i = 0; i < p; i++) exp_pw.push_back('{addr: i, data: int'(stream[1+i])});
    t = int'(stream[1+p]);
    if (t == 0) begin
      exp_err = 1'b1;
      exp_consumed = p + 2;
      return;
    end
    exp_tl = t;
    for (int i = 0; i < t; i++) exp_tw.push_back('{addr: i, data: int'(stream[2+p+i])});
    exp_consumed = p + 2 + t;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    search_done = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready_low", in_ready, 0);
    check("rst_outputs", {pat_we, pat_addr, pat_wdata, txt_we, txt_addr, txt_wdata,
                          pat_len, txt_len, start, busy, err}, 0);
    rst = 1'b0;
    #1;
    check("rst_idle_ready", in_ready, 1);
    exp_pl = 0;
    exp_tl = 0;
  endtask

  task automatic send(input int nbytes, input int gap, input bit sd_noise, output int cycles);
    int   n;
    int   budget;
    bit   v;
    logic rdy;
    n = 0;
    cycles = 0;
    budget = 20 * nbytes + 50;
    while (n < nbytes && budget > 0) begin
      v = (int'($urandom_range(99)) >= gap);
      in_valid = v;
      in_data = v ? stream[n] : 8'($urandom);
      search_done = sd_noise ? 1'($urandom_range(1)) : 1'b0;
      rdy = in_ready;
      @(posedge clk); #1;
      cycles++;
      budget--;
      if (v && rdy) n++;
    end
    in_valid = 1'b0;
    search_done = 1'b0;
    check("send_consumed", n, nbytes);
  endtask

  task automatic cmp_writes;
    check("pat_wr_count", pat_log.size(), exp_pw.size());
    for (int i = 0; i < exp_pw.size() && i < pat_log.size(); i++)
      check($sformatf("pat_wr[%0d]", i), pat_log[i].addr * 256 + pat_log[i].data,
            exp_pw[i].addr * 256 + exp_pw[i].data);
    check("txt_wr_count", txt_log.size(), exp_tw.size());
    for (int i = 0; i < exp_tw.size() && i < txt_log.size(); i++)
      check($sformatf("txt_wr[%0d]", i), txt_log[i].addr * 256 + txt_log[i].data,
            exp_tw[i].addr * 256 + exp_tw[i].data);
  endtask

  task automatic run_stream(input int gap, input bit sd_noise, input bit chk_tput);
    int cycles;
    int errs;
    pat_log.delete();
    txt_log.delete();
    start_cnt = 0;
    start_cyc = -1;
    last_txt_cyc = -1;
    overlap = 0;
    model();
    send(exp_consumed, gap, sd_noise, cycles);
    if (chk_tput) check("throughput_cycles", cycles, exp_consumed);
    if (!exp_err) begin
      check("ready_low_after_last", in_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      check("start_count", start_cnt, 1);
      check("start_latency", start_cyc - last_txt_cyc, 1);
      check("start_overlap", overlap, 0);
      check("wait_ready", in_ready, 0);
      check("wait_busy", busy, 1);
      search_done = 1'b1;
      @(posedge clk); #1;
      search_done = 1'b0;
      check("done_ready", in_ready, 1);
      check("done_busy", busy, 0);
    end else begin
      errs = 0;
      in_valid = 1'b1;
      repeat (20) begin
        in_data = 8'($urandom);
        search_done = 1'($urandom_range(1));
        @(posedge clk); #1;
        if (!(err === 1'b1 && in_ready === 1'b0 && busy === 1'b0 && start === 1'b0)) errs++;
      end
      in_valid = 1'b0;
      search_done = 1'b0;
      check("err_sticky", errs, 0);
    end
    check("err_flag", err, exp_err);
    check("pat_len", pat_len, exp_pl);
    check("txt_len", txt_len, exp_tl);
    cmp_writes();
  endtask

  task automatic build(input int p, input int t);
    stream.delete();
    stream.push_back(8'(p));
    if (p >= 1 && p <= (1 << PAT_AW)) begin
      repeat (p) stream.push_back(8'($urandom));
      stream.push_back(8'(t));
      repeat (t) stream.push_back(8'($urandom));
    end
  endtask

  typedef struct {
    int p;
    int t;
    int gap;
    bit e;
    int pl;
    int tl;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] fixed[12];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_used;

    vecs[0] = '{p: 4, t: 6,   gap: 0,  e: 1'b0, pl: 4, tl: 6};
    vecs[1] = '{p: 8, t: 1,   gap: 30, e: 1'b0, pl: 8, tl: 1};
    vecs[2] = '{p: 1, t: 255, gap: 40, e: 1'b0, pl: 1, tl: 255};
    vecs[3] = '{p: 0, t: 5,   gap: 20, e: 1'b1, pl: 0, tl: 0};
    vecs[4] = '{p: 9, t: 5,   gap: 0,  e: 1'b1, pl: 0, tl: 0};
    vecs[5] = '{p: 3, t: 0,   gap: 25, e: 1'b1, pl: 3, tl: 0};
    vecs[6] = '{p: 5, t: 200, gap: 0,  e: 1'b0, pl: 5, tl: 200};
    vecs[7] = '{p: 2, t: 3,   gap: 60, e: 1'b0, pl: 2, tl: 3};

    fixed = '{8'd4, 8'h61, 8'h62, 8'h63, 8'h64, 8'd6,
              8'h78, 8'h61, 8'h62, 8'h63, 8'h64, 8'h79};

    #1;
    do_reset();
    mon_en = 1'b1;

    // Table of stream shapes, each from reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      build(vecs[i].p, vecs[i].t);
      run_stream(vecs[i].gap, 1'b1, vecs[i].gap == 0);
      check($sformatf("tbl%0d_err", i), err, vecs[i].e);
      check($sformatf("tbl%0d_pat_len", i), pat_len, vecs[i].pl);
      check($sformatf("tbl%0d_txt_len", i), txt_len, vecs[i].tl);
    end

    // Literal stream, valid held high, then a second stream without reset.
    do_reset();
    stream.delete();
    foreach (fixed[i]) stream.push_back(fixed[i]);
    run_stream(0, 1'b1, 1'b1);
    check("lit_pat_len", pat_len, 4);
    check("lit_txt_len", txt_len, 6);
    build(2, 3);
    run_stream(30, 1'b1, 1'b0);

    // Reset after two of four pattern bytes, then a clean reload.
    do_reset();
    stream.delete();
    foreach (fixed[i]) stream.push_back(fixed[i]);
    pat_log.delete();
    txt_log.delete();
    send(3, 0, 1'b0, cyc_used);
    do_reset();
    check("midrst_pat_writes", pat_log.size(), 2);
    check("midrst_txt_writes", txt_log.size(), 0);
    build(4, 5);
    run_stream(20, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
